// File: rtl/draw_pkg.sv
// Shared definitions for the VGA drawing path: screen size, default widths,
// scheduler state encoding and requester slot assignments.
package draw_pkg;

  localparam int SCREEN_W    = 160;
  localparam int SCREEN_H    = 120;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_X_W     = 8;
  localparam int DEF_Y_W     = 7;
  localparam int DEF_C_W     = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DRAW = 2'b01,
    DONE = 2'b10
  } state_t;

  // Requester slots as wired in the game top level
  localparam int REQ_BRICK        = 0;
  localparam int REQ_PADDLE_ERASE = 1;
  localparam int REQ_PADDLE_DRAW  = 2;
  localparam int REQ_BALL         = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requesting index at or after
// ptr, counting cyclically, gets a one-hot grant.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic               valid
);

  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_grant;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
  assign rot_req   = NUM_REQ'({req, req} >> ptr);
  assign rot_grant = rot_req & (~rot_req + 1'b1);
  assign grant     = NUM_REQ'(({rot_grant, rot_grant} << ptr) >> NUM_REQ);
  assign valid     = |req;

endmodule

// File: rtl/rect_draw_scheduler.sv
// Round-robin scheduler that scans one solid rectangle at a time onto the VGA
// pixel-write port. Define RECT_CLIP_EN to suppress plot for off-screen pixels.
module rect_draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*X_W-1:0] rect_x,
  input  logic [NUM_REQ*Y_W-1:0] rect_y,
  input  logic [NUM_REQ*X_W-1:0] rect_w,
  input  logic [NUM_REQ*Y_W-1:0] rect_h,
  input  logic [NUM_REQ*C_W-1:0] rect_c,
  output logic [NUM_REQ-1:0]     done,
  output logic                   busy,
  output logic [X_W-1:0]         x,
  output logic [Y_W-1:0]         y,
  output logic [C_W-1:0]         colour,
  output logic                   plot
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
`ifdef RECT_CLIP_EN
  localparam int XS_W = X_W + 1;
  localparam int YS_W = Y_W + 1;
`else
  localparam int XS_W = X_W;
  localparam int YS_W = Y_W;
`endif

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gidx;
  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] gmask;
  logic [NUM_REQ-1:0] arb_grant;
  logic               arb_valid;

  logic [X_W-1:0] sx [NUM_REQ];
  logic [Y_W-1:0] sy [NUM_REQ];
  logic [X_W-1:0] sw [NUM_REQ];
  logic [Y_W-1:0] sh [NUM_REQ];
  logic [C_W-1:0] sc [NUM_REQ];

  logic [X_W-1:0] x0, w, cx, ncx;
  logic [Y_W-1:0] y0, h, cy, ncy;
  logic           last_col, last_pix, zero_area;
  logic [XS_W-1:0] xs_grant, xs_draw;
  logic [YS_W-1:0] ys_grant, ys_draw;
  logic           grant_on, draw_on;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign sx[i] = rect_x[i*X_W +: X_W];
    assign sy[i] = rect_y[i*Y_W +: Y_W];
    assign sw[i] = rect_w[i*X_W +: X_W];
    assign sh[i] = rect_h[i*Y_W +: Y_W];
    assign sc[i] = rect_c[i*C_W +: C_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .valid (arb_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) win_idx = PTR_W'(i);
    end
  end

  assign zero_area = (sw[win_idx] == '0) || (sh[win_idx] == '0);

  // Outputs are registered one pixel ahead: the scan position after this edge.
  assign last_col = (cx == w - 1'b1);
  assign last_pix = last_col && (cy == h - 1'b1);
  assign ncx      = last_col ? '0 : cx + 1'b1;
  assign ncy      = last_col ? cy + 1'b1 : cy;

  assign xs_grant = XS_W'(sx[win_idx]);
  assign ys_grant = YS_W'(sy[win_idx]);
  assign xs_draw  = XS_W'(x0) + XS_W'(ncx);
  assign ys_draw  = YS_W'(y0) + YS_W'(ncy);

`ifdef RECT_CLIP_EN
  function automatic logic on_screen(input logic [XS_W-1:0] xs, input logic [YS_W-1:0] ys);
    return (xs < XS_W'(SCREEN_W)) && (ys < YS_W'(SCREEN_H));
  endfunction

  assign grant_on = on_screen(xs_grant, ys_grant);
  assign draw_on  = on_screen(xs_draw, ys_draw);
`else
  assign grant_on = 1'b1;
  assign draw_on  = 1'b1;
`endif

  // Rectangle geometry is captured at grant and needs no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && arb_valid) begin
      x0 <= sx[win_idx];
      y0 <= sy[win_idx];
      w  <= sw[win_idx];
      h  <= sh[win_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gidx   <= '0;
      gmask  <= '0;
      cx     <= '0;
      cy     <= '0;
      done   <= '0;
      busy   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          plot <= 1'b0;
          if (arb_valid) begin
            gidx  <= win_idx;
            gmask <= arb_grant;
            cx    <= '0;
            cy    <= '0;
            busy  <= 1'b1;
            if (zero_area) begin
              state <= DONE;
              done  <= arb_grant;
            end else begin
              state  <= DRAW;
              x      <= xs_grant[X_W-1:0];
              y      <= ys_grant[Y_W-1:0];
              colour <= sc[win_idx];
              plot   <= grant_on;
            end
          end
        end
        DRAW: begin
          if (last_pix) begin
            state <= DONE;
            plot  <= 1'b0;
            done  <= gmask;
          end else begin
            cx   <= ncx;
            cy   <= ncy;
            x    <= xs_draw[X_W-1:0];
            y    <= ys_draw[Y_W-1:0];
            plot <= draw_on;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          plot  <= 1'b0;
          ptr   <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule
